mem_arbiter: RTL and testbench

// - Two-requester round-robin controller for the single-port 16x8 sync memory (wr/rd strobes, 1-cycle read latency).
// - Sits between two masters and the memory.
// - Latches one command per transaction, sequences the wr/rd strobes and returns read data per requester.
// - Guarantees the memory never sees wr and rd in the same cycle.

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/rr_arb2.sv | 21 ++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizes for the memory arbiter slice.
package mem_ctrl_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  // state | meaning
  // IDLE  | waiting for a request, only state that arbitrates
  // ACC   | command issued to the memory, grant pulse visible
  // RDW   | read data coming back from the memory this cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RDW  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: when both request, the one that did not win
// last time gets the slot; otherwise the single requester wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       idx,
  output logic       any
);

  // pure combinational pick, no history kept here (the owner of 'last' is the FSM)
  always_comb begin
    any = |req;
    idx = 1'b0;
    if (req == 2'b11) begin
      idx = ~last;
    end else begin
      idx = req[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin front end for a single-port sync memory shared by two masters.
// One command is latched per transaction; all outputs are registered, and the
// wr/rd strobes are only ever raised in ACC, so they cannot overlap.
//
// state | meaning
// IDLE  | sample req0/req1, pick an owner, latch its command
// ACC   | gnt pulse to owner, strobe the memory with the latched command
// RDW   | capture mem_dout for the owner, rvalid follows on the next cycle
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          busy,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  state_t        state;
  logic          last;
  logic          cmd_owner;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic [1:0]    req_vec;
  logic          pick_idx;
  logic          pick_any;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req_vec = {req1, req0};

  rr_arb2 u_arb (
    .req  (req_vec),
    .last (last),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // route the winning master's command toward the cmd registers
  always_comb begin
    sel_we    = we0;
    sel_addr  = addr0;
    sel_wdata = wdata0;
    if (pick_idx) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end
  end

  // the memory address/data buses are the latched command itself, so they
  // hold the last command's values once the strobes drop
  assign mem_ad  = cmd_addr;
  assign mem_din = cmd_wdata;

  // transaction sequencer; every output is set one edge ahead of the state it belongs to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      cmd_owner <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      busy      <= 1'b0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_wr  <= 1'b0;
      mem_rd  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            cmd_owner <= pick_idx;
            cmd_we    <= sel_we;
            cmd_addr  <= sel_addr;
            cmd_wdata <= sel_wdata;
            last      <= pick_idx;
            gnt0      <= ~pick_idx;
            gnt1      <= pick_idx;
            mem_wr    <= sel_we;
            mem_rd    <= ~sel_we;
            busy      <= 1'b1;
            state     <= ACC;
          end
        end
        ACC: begin
          if (cmd_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= RDW;
          end
        end
        RDW: begin
          // mem_dout is only meaningful here; the memory floats it otherwise
          if (cmd_owner) begin
            rdata1  <= mem_dout;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_dout;
            rvalid0 <= 1'b1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic from two
// masters, checked by a cycle-level transaction model and a negedge monitor.
module tb_mem_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, mem_wr, mem_rd;
  logic [DW-1:0] rdata0, rdata1, mem_din;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_ad(mem_ad), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  function automatic logic [7:0] preset(input int i);
    return 8'((i * 37 + 90) ^ (i << 4));
  endfunction

  // environment: 16x8 sync memory, loaded once, garbage on the output when not read
  logic [DW-1:0] mem [16];
  logic          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!rst) begin
      if (!mem_loaded) for (int i = 0; i < 16; i++) mem[i] <= preset(i);
      mem_loaded <= 1'b1;
      mem_dout   <= '0;
    end else begin
      if (mem_wr) mem[mem_ad] <= mem_din;
      mem_dout <= mem_rd ? mem[mem_ad] : 8'($urandom);
    end
  end

  // reference model: transaction timing from the latency rules
  typedef struct { int cyc; logic [7:0] data; } rd_exp_t;
  int            cyc = 0;
  int            free_at = 0;
  int            acc_cyc = -1;
  logic          acc_we = 1'b0;
  logic [AW-1:0] exp_ad = '0;
  logic [DW-1:0] exp_din = '0;
  logic          m_last = 1'b1;
  logic          ref_loaded = 1'b0;
  logic [7:0]    ref_mem [16];
  int            gq0[$], gq1[$];
  rd_exp_t       rq0[$], rq1[$];
  logic          own, w;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  rd_exp_t       e;

  always @(posedge clk) begin
    if (!rst) begin
      if (!ref_loaded) for (int i = 0; i < 16; i++) ref_mem[i] = preset(i);
      ref_loaded = 1'b1;
      m_last = 1'b1; free_at = 0; acc_cyc = -1; acc_we = 1'b0;
      exp_ad = '0; exp_din = '0;
      gq0.delete(); gq1.delete(); rq0.delete(); rq1.delete();
    end else begin
      if (acc_we && cyc == acc_cyc) ref_mem[exp_ad] = exp_din;
      if (cyc >= free_at && (req0 || req1)) begin
        own = (req0 && req1) ? ~m_last : req1;
        w = own ? we1 : we0;
        a = own ? addr1 : addr0;
        d = own ? wdata1 : wdata0;
        m_last = own; acc_cyc = cyc + 1; acc_we = w; exp_ad = a; exp_din = d;
        if (own) gq1.push_back(cyc + 1); else gq0.push_back(cyc + 1);
        if (w) begin
          free_at = cyc + 2;
        end else begin
          e.cyc = cyc + 3; e.data = ref_mem[a];
          if (own) rq1.push_back(e); else rq0.push_back(e);
          free_at = cyc + 3;
        end
      end
    end
    cyc++;
  end

  // monitor / scoreboard
  int         checks = 0, errors = 0;
  int         to_req = 0, to_seen = 0;
  logic       eg0, eg1, ev0, ev1;
  logic [7:0] exp_rdata0 = '0, exp_rdata1 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("reset_outputs", 64'({gnt0, gnt1, rvalid0, rvalid1, busy, mem_wr, mem_rd,
                                mem_ad, mem_din, rdata0, rdata1}), 64'd0);
      exp_rdata0 = '0; exp_rdata1 = '0;
    end else begin
      eg0 = (gq0.size() > 0) && (gq0[0] == cyc);
      if (eg0) void'(gq0.pop_front());
      eg1 = (gq1.size() > 0) && (gq1[0] == cyc);
      if (eg1) void'(gq1.pop_front());
      ev0 = (rq0.size() > 0) && (rq0[0].cyc == cyc);
      if (ev0) begin exp_rdata0 = rq0[0].data; void'(rq0.pop_front()); end
      ev1 = (rq1.size() > 0) && (rq1[0].cyc == cyc);
      if (ev1) begin exp_rdata1 = rq1[0].data; void'(rq1.pop_front()); end
      chk("gnt0", 64'(gnt0), 64'(eg0));
      chk("gnt1", 64'(gnt1), 64'(eg1));
      chk("rvalid0", 64'(rvalid0), 64'(ev0));
      chk("rvalid1", 64'(rvalid1), 64'(ev1));
      chk("rdata0", 64'(rdata0), 64'(exp_rdata0));
      chk("rdata1", 64'(rdata1), 64'(exp_rdata1));
      chk("busy", 64'(busy), 64'(cyc < free_at));
      chk("mem_wr", 64'(mem_wr), 64'(cyc == acc_cyc && acc_we));
      chk("mem_rd", 64'(mem_rd), 64'(cyc == acc_cyc && !acc_we));
      chk("mem_ad", 64'(mem_ad), 64'(exp_ad));
      chk("mem_din", 64'(mem_din), 64'(exp_din));
      chk("wr_rd_exclusive", 64'(mem_wr & mem_rd), 64'd0);
    end
    chk("txn_timeout", 64'(to_req), 64'(to_seen));
    to_seen = to_req;
  end

  // master driver: call at a negedge; returns at the negedge where gnt is seen
  task automatic do_txn(input int m, input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] dat);
    int   n = 0;
    logic g = 1'b0;
    if (m == 0) begin we0 = wr; addr0 = ad; wdata0 = dat; req0 = 1'b1; end
    else        begin we1 = wr; addr1 = ad; wdata1 = dat; req1 = 1'b1; end
    while (!g && n < 40) begin
      @(negedge clk);
      n++;
      g = (m == 0) ? gnt0 : gnt1;
    end
    if (!g) begin
      to_req++;
      $display("FAIL grant_wait master %0d: got no gnt within %0d cycles, required gnt", m, n);
    end
    if (m == 0) begin req0 = 1'b0; we0 = 1'($urandom); addr0 = 4'($urandom); wdata0 = 8'($urandom); end
    else        begin req1 = 1'b0; we1 = 1'($urandom); addr1 = 4'($urandom); wdata1 = 8'($urandom); end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);

    // single write, then a read of the same location by the other master
    do_txn(0, 1'b1, 4'd3, 8'hA5);
    do_txn(1, 1'b0, 4'd3, 8'h00);
    repeat (3) @(negedge clk);

    // both masters reading the address extremes back-to-back
    fork
      for (int k = 0; k < 4; k++) do_txn(0, 1'b0, 4'd0, 8'h00);
      for (int k = 0; k < 4; k++) do_txn(1, 1'b0, 4'd15, 8'h00);
    join
    repeat (3) @(negedge clk);

    // simultaneous write (m0) and read (m1) of the same address
    fork
      do_txn(0, 1'b1, 4'd5, 8'h11);
      do_txn(1, 1'b0, 4'd5, 8'h00);
    join
    repeat (3) @(negedge clk);

    // reset during RDW of a read
    do_txn(0, 1'b0, 4'd6, 8'h00);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    fork
      do_txn(1, 1'b0, 4'd2, 8'h00);
      do_txn(0, 1'b0, 4'd1, 8'h00);
    join
    repeat (3) @(negedge clk);

    // reset during ACC of a write: the write must not land
    do_txn(1, 1'b1, 4'd8, 8'h3C);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    do_txn(0, 1'b0, 4'd8, 8'h00);
    repeat (3) @(negedge clk);

    // req0 pulsed only while busy: no grant for it
    we1 = 1'b0; addr1 = 4'd9; req1 = 1'b1;
    n = 0;
    while (!gnt1 && n < 40) begin @(negedge clk); n++; end
    if (!gnt1) to_req++;
    req1 = 1'b0; we0 = 1'b1; addr0 = 4'd2; wdata0 = 8'h77; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    repeat (4) @(negedge clk);

    // random traffic
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(0, 1'($urandom), 4'($urandom), 8'($urandom));
      end
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_txn(1, 1'($urandom), 4'($urandom), 8'($urandom));
      end
    join
    repeat (6) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
